// File: rtl/timekeeper_pkg.sv
// Shared constants and helpers for the watch/stopwatch datapath.
package timekeeper_pkg;

    // Display source select
    localparam logic [1:0] DISP_WATCH     = 2'd0;
    localparam logic [1:0] DISP_SW        = 2'd1;
    localparam logic [1:0] DISP_LAP       = 2'd2;
    localparam logic [1:0] DISP_WATCH_ALT = 2'd3;

    // Watch set cursor
    localparam logic [1:0] CUR_SEC  = 2'd0;
    localparam logic [1:0] CUR_MIN  = 2'd1;
    localparam logic [1:0] CUR_HOUR = 2'd2;
    localparam logic [1:0] CUR_NONE = 2'd3;

    // Time field widths and limits
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOUR_W  = 5;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // One modular step of a field in 0..top; down=1 steps backwards.
    function automatic logic [7:0] wrap_step(input logic [7:0] v,
                                             input logic [7:0] top,
                                             input logic       down);
        if (down)
            return (v == 8'd0) ? top : v - 8'd1;
        else
            return (v == top) ? 8'd0 : v + 8'd1;
    endfunction

endpackage

// File: rtl/time_counter.sv
// hh:mm:ss.cc counter with tick enable, up/down, per-field stepping and
// optional hold-at-zero when counting down. Used for watch and stopwatch.
module time_counter
    import timekeeper_pkg::*;
#(
    parameter int TICK_HZ    = 100,
    parameter int HOUR_MOD   = 24,
    parameter int RESET_HOUR = 12,
    parameter int MSEC_W     = $clog2(TICK_HZ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              tick,
    input  logic              run,
    input  logic              down,
    input  logic              sat_zero,
    input  logic              step_inc,
    input  logic              step_dec,
    input  logic [1:0]        step_field,
    output logic [MSEC_W-1:0] msec,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour
);

    localparam logic [MSEC_W-1:0] MSEC_TOP = MSEC_W'(TICK_HZ - 1);
    localparam logic [SEC_W-1:0]  SEC_TOP  = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0]  MIN_TOP  = MIN_W'(MIN_MAX);
    localparam logic [HOUR_W-1:0] HOUR_TOP = HOUR_W'(HOUR_MOD - 1);
    localparam logic [HOUR_W-1:0] HOUR_RST = HOUR_W'(RESET_HOUR);

    logic [MSEC_W-1:0] msec_reg, msec_next;
    logic [SEC_W-1:0]  sec_reg, sec_next;
    logic [MIN_W-1:0]  min_reg, min_next;
    logic [HOUR_W-1:0] hour_reg, hour_next;
    logic              pend_reg;
    logic              step_act, adv, hold, ms_edge, s_edge, m_edge;

    assign adv = tick && run;

    // Next value for one count step, with carry (up) or borrow (down) chain
    always_comb begin
        step_act  = (step_inc ^ step_dec) && (step_field != CUR_NONE);
        hold      = down && sat_zero && (msec_reg == '0) && (sec_reg == '0)
                    && (min_reg == '0) && (hour_reg == '0);
        ms_edge   = down ? (msec_reg == '0) : (msec_reg == MSEC_TOP);
        s_edge    = down ? (sec_reg == '0)  : (sec_reg == SEC_TOP);
        m_edge    = down ? (min_reg == '0)  : (min_reg == MIN_TOP);
        msec_next = MSEC_W'(wrap_step(8'(msec_reg), 8'(MSEC_TOP), down));
        sec_next  = ms_edge ? SEC_W'(wrap_step(8'(sec_reg), 8'(SEC_TOP), down)) : sec_reg;
        min_next  = (ms_edge && s_edge)
                    ? MIN_W'(wrap_step(8'(min_reg), 8'(MIN_TOP), down)) : min_reg;
        hour_next = (ms_edge && s_edge && m_edge)
                    ? HOUR_W'(wrap_step(8'(hour_reg), 8'(HOUR_TOP), down)) : hour_reg;
    end

    // Clear beats stepping beats counting; a tick that meets a step waits in pend_reg
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msec_reg <= '0;
            sec_reg  <= '0;
            min_reg  <= '0;
            hour_reg <= HOUR_RST;
            pend_reg <= 1'b0;
        end else if (clr) begin
            msec_reg <= '0;
            sec_reg  <= '0;
            min_reg  <= '0;
            hour_reg <= HOUR_RST;
            pend_reg <= 1'b0;
        end else if (step_act) begin
            pend_reg <= pend_reg || adv;
            case (step_field)
                CUR_SEC: begin
                    sec_reg  <= SEC_W'(wrap_step(8'(sec_reg), 8'(SEC_TOP), step_dec));
                    msec_reg <= '0;
                end
                CUR_MIN:  min_reg  <= MIN_W'(wrap_step(8'(min_reg), 8'(MIN_TOP), step_dec));
                CUR_HOUR: hour_reg <= HOUR_W'(wrap_step(8'(hour_reg), 8'(HOUR_TOP), step_dec));
                default: ;
            endcase
        end else if (adv || pend_reg) begin
            pend_reg <= 1'b0;
            if (!hold) begin
                msec_reg <= msec_next;
                sec_reg  <= sec_next;
                min_reg  <= min_next;
                hour_reg <= hour_next;
            end
        end
    end

    assign msec = msec_reg;
    assign sec  = sec_reg;
    assign min  = min_reg;
    assign hour = hour_reg;

endmodule

// File: rtl/timekeeper_datapath.sv
// Watch + stopwatch datapath: shared tick prescaler, lap buffer with recall,
// and a registered display mux feeding the FND controller.
module timekeeper_datapath
    import timekeeper_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 100,
    parameter int HOUR_MOD   = 24,
    parameter int RESET_HOUR = 12,
    parameter int LAP_DEPTH  = 4,
    localparam int MSEC_W    = $clog2(TICK_HZ),
    localparam int LAP_AW    = $clog2(LAP_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        i_disp_sel,
    input  logic              i_sw_mode,
    input  logic              i_sw_run_stop,
    input  logic              i_sw_clear,
    input  logic              i_lap,
    input  logic              i_lap_next,
    input  logic [1:0]        i_w_cursor,
    input  logic              i_w_inc,
    input  logic              i_w_dec,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic [LAP_AW-1:0] o_lap_idx,
    output logic [LAP_AW:0]   o_lap_count,
    output logic              o_lap_full,
    output logic              o_sw_zero
);

    localparam int TIME_W   = HOUR_W + MIN_W + SEC_W + MSEC_W;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP  = PRE_W'(TICK_DIV - 1);
    localparam logic [LAP_AW:0]  LAP_FULL = (LAP_AW + 1)'(LAP_DEPTH);

    logic [PRE_W-1:0]  presc_reg;
    logic              tick;
    logic [MSEC_W-1:0] w_msec, s_msec;
    logic [SEC_W-1:0]  w_sec, s_sec;
    logic [MIN_W-1:0]  w_min, s_min;
    logic [HOUR_W-1:0] w_hour, s_hour;
    logic [TIME_W-1:0] watch_time, sw_time, lap_rd, disp_reg;
    logic [TIME_W-1:0] lap_mem [LAP_DEPTH];
    logic [LAP_AW:0]   lap_count_reg;
    logic [LAP_AW-1:0] lap_idx_reg, lap_wr_ptr;
    logic              lap_wr, sw_arm_reg, sw_zero_reg;

    // Free-running prescaler; clear never touches it so watch timing is undisturbed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            presc_reg <= '0;
        else
            presc_reg <= (presc_reg == PRE_TOP) ? '0 : presc_reg + 1'b1;
    end

    assign tick = (presc_reg == PRE_TOP);

    time_counter #(
        .TICK_HZ(TICK_HZ), .HOUR_MOD(HOUR_MOD), .RESET_HOUR(RESET_HOUR), .MSEC_W(MSEC_W)
    ) u_watch (
        .clk(clk), .reset(reset), .clr(1'b0), .tick(tick), .run(1'b1),
        .down(1'b0), .sat_zero(1'b0),
        .step_inc(i_w_inc), .step_dec(i_w_dec), .step_field(i_w_cursor),
        .msec(w_msec), .sec(w_sec), .min(w_min), .hour(w_hour)
    );

    time_counter #(
        .TICK_HZ(TICK_HZ), .HOUR_MOD(HOUR_MOD), .RESET_HOUR(0), .MSEC_W(MSEC_W)
    ) u_stopwatch (
        .clk(clk), .reset(reset), .clr(i_sw_clear), .tick(tick), .run(i_sw_run_stop),
        .down(i_sw_mode), .sat_zero(1'b1),
        .step_inc(1'b0), .step_dec(1'b0), .step_field(CUR_NONE),
        .msec(s_msec), .sec(s_sec), .min(s_min), .hour(s_hour)
    );

    assign watch_time = {w_hour, w_min, w_sec, w_msec};
    assign sw_time    = {s_hour, s_min, s_sec, s_msec};

    // Zero flag: armed by a down-count tick, shown only while the count sits at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_arm_reg  <= 1'b0;
            sw_zero_reg <= 1'b0;
        end else begin
            if (i_sw_clear || !i_sw_mode)
                sw_arm_reg <= 1'b0;
            else if (i_sw_run_stop && tick)
                sw_arm_reg <= 1'b1;
            sw_zero_reg <= !i_sw_clear && i_sw_mode && sw_arm_reg && (sw_time == '0);
        end
    end

    // Laps are never overwritten, so the write pointer is simply the fill count
    assign lap_wr_ptr = lap_count_reg[LAP_AW-1:0];
    assign lap_wr     = i_lap && !i_sw_clear && (lap_count_reg != LAP_FULL);

    // Lap storage captures the pre-tick stopwatch value
    always_ff @(posedge clk) begin
        if (lap_wr)
            lap_mem[lap_wr_ptr] <= sw_time;
    end

    // Fill count and recall index; clear empties the buffer and rewinds recall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_count_reg <= '0;
            lap_idx_reg   <= '0;
        end else if (i_sw_clear) begin
            lap_count_reg <= '0;
            lap_idx_reg   <= '0;
        end else begin
            if (lap_wr)
                lap_count_reg <= lap_count_reg + 1'b1;
            if (i_lap_next && (lap_count_reg != '0))
                lap_idx_reg <= ({1'b0, lap_idx_reg} == lap_count_reg - 1'b1)
                               ? '0 : lap_idx_reg + 1'b1;
        end
    end

    // Empty buffer recalls as all zeros
    always_comb begin
        lap_rd = '0;
        if (lap_count_reg != '0)
            lap_rd = lap_mem[lap_idx_reg];
    end

    // Display register reloads the selected source every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_reg <= '0;
        end else begin
            case (i_disp_sel)
                DISP_SW:  disp_reg <= sw_time;
                DISP_LAP: disp_reg <= lap_rd;
                default:  disp_reg <= watch_time;
            endcase
        end
    end

    assign o_msec      = disp_reg[MSEC_W-1:0];
    assign o_sec       = disp_reg[MSEC_W +: SEC_W];
    assign o_min       = disp_reg[MSEC_W+SEC_W +: MIN_W];
    assign o_hour      = disp_reg[MSEC_W+SEC_W+MIN_W +: HOUR_W];
    assign o_lap_idx   = lap_idx_reg;
    assign o_lap_count = lap_count_reg;
    assign o_lap_full  = (lap_count_reg == LAP_FULL);
    assign o_sw_zero   = sw_zero_reg;

endmodule

// File: tb/tb_timekeeper_datapath.sv
// Bench for timekeeper_datapath at CLK_HZ=1000, TICK_HZ=100 (tick every 10 clk).
module tb_timekeeper_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] i_disp_sel = 2'd0;
    logic       i_sw_mode = 1'b0;
    logic       i_sw_run_stop = 1'b0;
    logic       i_sw_clear = 1'b0;
    logic       i_lap = 1'b0;
    logic       i_lap_next = 1'b0;
    logic [1:0] i_w_cursor = 2'd3;
    logic       i_w_inc = 1'b0;
    logic       i_w_dec = 1'b0;
    logic [6:0] o_msec;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic [1:0] o_lap_idx;
    logic [2:0] o_lap_count;
    logic       o_lap_full, o_sw_zero;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    timekeeper_datapath #(
        .CLK_HZ(1000), .TICK_HZ(100), .HOUR_MOD(24), .RESET_HOUR(12), .LAP_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .i_disp_sel(i_disp_sel), .i_sw_mode(i_sw_mode),
        .i_sw_run_stop(i_sw_run_stop), .i_sw_clear(i_sw_clear), .i_lap(i_lap),
        .i_lap_next(i_lap_next), .i_w_cursor(i_w_cursor), .i_w_inc(i_w_inc),
        .i_w_dec(i_w_dec), .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min),
        .o_hour(o_hour), .o_lap_idx(o_lap_idx), .o_lap_count(o_lap_count),
        .o_lap_full(o_lap_full), .o_sw_zero(o_sw_zero)
    );

    always #5 clk = ~clk;

    // Edges since reset release; edge N is the N-th rising edge with reset high
    always @(posedge clk) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: cyc=%0d required finish before timeout", cyc);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] pk(input int h, input int m, input int s, input int ms);
        return {8'd0, 5'(h), 6'(m), 6'(s), 7'(ms)};
    endfunction

    function automatic logic [31:0] disp();
        return {8'd0, o_hour, o_min, o_sec, o_msec};
    endfunction

    function automatic logic [31:0] all_outs();
        return {1'b0, o_hour, o_min, o_sec, o_msec, o_lap_idx, o_lap_count, o_lap_full, o_sw_zero};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cyc %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cyc %0d)", tag, got, cyc);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] got);
        sb_t e;
        if (sbq.size() == 0) begin
            check("sb_underflow", 32'(sbq.size()), 32'd1);
        end else begin
            e = sbq.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    // Land on the falling edge right after rising edge e
    task automatic goto(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 32'd0);
        reset = 1'b1;

        // ---- watch ----
        goto(1);    sb_push("watch_rst", pk(12, 0, 0, 0));   sb_check(disp());
        i_disp_sel = 2'd3;
        goto(3);    sb_push("watch_sel3", pk(12, 0, 0, 0));  sb_check(disp());
        i_disp_sel = 2'd0;
        goto(1000); sb_push("watch_999", pk(12, 0, 0, 99));  sb_check(disp());
        goto(1001); sb_push("watch_1s", pk(12, 0, 1, 0));    sb_check(disp());
        i_w_cursor = 2'd2; i_w_dec = 1'b1;                   // 13 hour decrements
        goto(1014); i_w_cursor = 2'd1;                       // one minute decrement
        goto(1015); i_w_dec = 1'b0;
        goto(1021); i_w_cursor = 2'd0; i_w_dec = 1'b1;       // sec 1 -> 0 -> 59
        goto(1023); i_w_dec = 1'b0; i_w_cursor = 2'd3;
        goto(1024); sb_push("watch_set", pk(23, 59, 59, 0)); sb_check(disp());
        goto(2020); sb_push("watch_pre_wrap", pk(23, 59, 59, 99)); sb_check(disp());
        goto(2021); sb_push("watch_wrap", pk(0, 0, 0, 0));   sb_check(disp());
        i_w_cursor = 2'd1; i_w_dec = 1'b1;
        goto(2022); i_w_dec = 1'b0;
        goto(2023); sb_push("min_dec_wrap", pk(0, 59, 0, 0)); sb_check(disp());
        goto(2029); i_w_cursor = 2'd0; i_w_inc = 1'b1;       // step lands on tick edge
        goto(2030); i_w_inc = 1'b0;
        goto(2031); sb_push("inc_on_tick", pk(0, 59, 1, 0)); sb_check(disp());
        goto(2032); sb_push("pending_tick", pk(0, 59, 1, 1)); sb_check(disp());
        goto(2033); i_w_cursor = 2'd1; i_w_inc = 1'b1; i_w_dec = 1'b1;
        goto(2034); i_w_inc = 1'b0; i_w_dec = 1'b0; i_w_cursor = 2'd3;
        goto(2035); sb_push("inc_dec_both", pk(0, 59, 1, 1)); sb_check(disp());
        goto(2036); reset = 1'b0; #1;
        check("reset_async_watch", all_outs(), 32'd0);

        // ---- stopwatch down to zero ----
        i_disp_sel = 2'd1; i_sw_mode = 1'b0; i_sw_run_stop = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b1;
        goto(30);  i_sw_run_stop = 1'b0;
        goto(32);  sb_push("sw_up3", pk(0, 0, 0, 3)); sb_check(disp());
        check("sw_zero_up", 32'(o_sw_zero), 32'd0);
        i_sw_mode = 1'b1; i_sw_run_stop = 1'b1;
        goto(41);  sb_push("sw_down2", pk(0, 0, 0, 2)); sb_check(disp());
        check("sw_zero_not_yet", 32'(o_sw_zero), 32'd0);
        goto(63);  sb_push("sw_down0", pk(0, 0, 0, 0)); sb_check(disp());
        check("sw_zero_set", 32'(o_sw_zero), 32'd1);
        goto(85);  sb_push("sw_hold0", pk(0, 0, 0, 0)); sb_check(disp());
        check("sw_zero_hold", 32'(o_sw_zero), 32'd1);
        i_sw_clear = 1'b1;
        goto(86);  i_sw_clear = 1'b0; i_sw_mode = 1'b0;
        goto(87);  check("sw_zero_clr", 32'(o_sw_zero), 32'd0);

        // ---- laps while counting up: sw = k-8 after tick edge 10k ----
        goto(94);  i_lap = 1'b1; sb_push("lap0", pk(0, 0, 0, 1));
        goto(95);  i_lap = 1'b0;
        goto(114); i_lap = 1'b1; sb_push("lap1", pk(0, 0, 0, 3));
        goto(115); i_lap = 1'b0;
        goto(116); check("lap_count2", 32'(o_lap_count), 32'd2);
        goto(134); i_lap = 1'b1; sb_push("lap2", pk(0, 0, 0, 5));
        goto(135); i_lap = 1'b0;
        goto(136); check("lap_count3_full", {28'd0, o_lap_count, o_lap_full}, {28'd0, 3'd3, 1'b0});
        goto(154); i_lap = 1'b1; sb_push("lap3", pk(0, 0, 0, 7));
        goto(155); i_lap = 1'b0;
        goto(174); i_lap = 1'b1;                              // buffer full: ignored
        goto(175); i_lap = 1'b0;
        goto(176); check("lap_count4_full", {28'd0, o_lap_count, o_lap_full}, {28'd0, 3'd4, 1'b1});
        goto(177); i_sw_run_stop = 1'b0; i_disp_sel = 2'd2;

        // ---- recall ----
        goto(179); sb_check(disp()); check("idx0", 32'(o_lap_idx), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            i_lap_next = 1'b1;
            goto(cyc + 1); i_lap_next = 1'b0;
            goto(cyc + 1); sb_check(disp()); check($sformatf("idx%0d", k), 32'(o_lap_idx), 32'(k));
        end
        i_lap_next = 1'b1;
        goto(186); i_lap_next = 1'b0;
        goto(187); check("recall_wrap", disp(), pk(0, 0, 0, 1));
        check("idx_wrap", 32'(o_lap_idx), 32'd0);

        // ---- clear coincident with tick and lap ----
        i_disp_sel = 2'd1; i_sw_run_stop = 1'b1;
        goto(189); i_sw_clear = 1'b1; i_lap = 1'b1;
        goto(190); i_sw_clear = 1'b0; i_lap = 1'b0;
        goto(191); sb_push("clr_sw", pk(0, 0, 0, 0)); sb_check(disp());
        check("clr_laps", {27'd0, o_lap_idx, o_lap_count, o_lap_full}, 32'd0);
        i_disp_sel = 2'd2;
        goto(193); sb_push("recall_empty", pk(0, 0, 0, 0)); sb_check(disp());
        i_disp_sel = 2'd1;
        goto(205); sb_push("sw_after_clr", pk(0, 0, 0, 1)); sb_check(disp());

        // ---- asynchronous reset while running ----
        reset = 1'b0; #1;
        check("reset_async_run", all_outs(), 32'd0);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
